seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Recovers hex digits from a multiplexed, active-low seven-segment bus.
// The bus is registered once, each anode window is debounced by a stability
// counter, and every debounced pattern is decoded into a working frame.
// A frame with every digit captured is handed to a valid/ready output
// register, or dropped with an overrun pulse if the consumer is stalled.

module seg7_scan_decoder #(
  parameter int NUM_DIG       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg_n,
  input  logic [NUM_DIG-1:0]     an_n,
  output logic [4*NUM_DIG-1:0]   frame_data,
  output logic [NUM_DIG-1:0]     frame_blank,
  output logic                   frame_err,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   overrun
);

  localparam int CW = 8;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [6:0]    PAT_BLANK  = 7'b1111111;

  // Sample register and its one-cycle-old copy used for the equality test
  logic [6:0]         seg_q, seg_p_q;
  logic [NUM_DIG-1:0] an_q, an_p_q;

  // Window debounce state
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               flag_q, flag_d;

  // Working frame
  logic [4*NUM_DIG-1:0] work_data_q, work_data_d;
  logic [NUM_DIG-1:0]   work_blank_q, work_blank_d;
  logic [NUM_DIG-1:0]   mask_q, mask_d;
  logic                 err_acc_q, err_acc_d;

  // Output register
  logic [4*NUM_DIG-1:0] out_data_q, out_data_d;
  logic [NUM_DIG-1:0]   out_blank_q, out_blank_d;
  logic                 out_err_q, out_err_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  // Combinational helpers
  logic               qual;
  logic [IW-1:0]      dig_idx;
  logic               same;
  logic               capture;
  logic [3:0]         dec_nib;
  logic               dec_blank;
  logic               dec_err;
  logic               complete;
  logic               load;
  logic               drop;

  // Pattern decode: returns {err, blank, nibble}
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b10_0000;
    case (p)
      7'b0000001: r = 6'h00;
      7'b1001111: r = 6'h01;
      7'b0010010: r = 6'h02;
      7'b0000110: r = 6'h03;
      7'b1001100: r = 6'h04;
      7'b0100100: r = 6'h05;
      7'b0100000: r = 6'h06;
      7'b0001111: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0000100: r = 6'h09;
      7'b0001000: r = 6'h0a;
      7'b1100000: r = 6'h0b;
      7'b0110001: r = 6'h0c;
      7'b1000010: r = 6'h0d;
      7'b0110000: r = 6'h0e;
      7'b0111000: r = 6'h0f;
      PAT_BLANK:  r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  // Register the raw bus and keep the previous sample for comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      an_q    <= '0;
      seg_p_q <= '0;
      an_p_q  <= '0;
    end else begin
      seg_q   <= seg_n;
      an_q    <= an_n;
      seg_p_q <= seg_q;
      an_p_q  <= an_q;
    end
  end

  // Qualify the sample (exactly one anode low) and find which digit it is
  always_comb begin
    int zeros;
    zeros   = 0;
    dig_idx = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!an_q[i]) begin
        zeros   = zeros + 1;
        dig_idx = IW'(i);
      end
    end
    qual = (zeros == 1);
    same = (seg_q == seg_p_q) && (an_q == an_p_q);
  end

  // Stability counter and once-per-window capture flag
  always_comb begin
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    capture = 1'b0;
    if (!qual) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (!same) begin
      cnt_d  = CW'(1);
      flag_d = 1'b0;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (qual && (cnt_d == STABLE_MAX) && !flag_d) begin
      capture = 1'b1;
      flag_d  = 1'b1;
    end
  end

  // Decode the sample currently on the bus
  always_comb begin
    logic [5:0] r;
    r         = decode_seg(seg_q);
    dec_nib   = r[3:0];
    dec_blank = r[4];
    dec_err   = r[5];
  end

  // Frame assembly, completion hand-off and output handshake
  always_comb begin
    complete = &mask_q;
    load     = complete && (!valid_q || frame_ready);
    drop     = complete && valid_q && !frame_ready;

    work_data_d  = work_data_q;
    work_blank_d = work_blank_q;
    mask_d       = complete ? '0 : mask_q;
    err_acc_d    = complete ? 1'b0 : err_acc_q;

    out_data_d  = out_data_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    valid_d     = valid_q;
    ovr_d       = drop;

    if (load) begin
      out_data_d  = work_data_q;
      out_blank_d = work_blank_q;
      out_err_d   = err_acc_q;
      valid_d     = 1'b1;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    if (capture) begin
      work_data_d[4*dig_idx +: 4] = dec_nib;
      work_blank_d[dig_idx]       = dec_blank;
      mask_d[dig_idx]             = 1'b1;
      err_acc_d                   = err_acc_d | dec_err;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  // Working frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_data_q  <= '0;
      work_blank_q <= '0;
      mask_q       <= '0;
      err_acc_q    <= 1'b0;
    end else begin
      work_data_q  <= work_data_d;
      work_blank_q <= work_blank_d;
      mask_q       <= mask_d;
      err_acc_q    <= err_acc_d;
    end
  end

  // Output frame registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_blank_q <= '0;
      out_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_blank_q <= out_blank_d;
      out_err_q   <= out_err_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign frame_data  = out_data_q;
  assign frame_blank = out_blank_q;
  assign frame_err   = out_err_q;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Directed scenarios plus a randomized scan, all compared cycle by cycle with
// a reference built from input run lengths and a pattern lookup table.

module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      seg_n;
  logic [ND-1:0]   an_n;
  logic            frame_ready;
  logic [4*ND-1:0] frame_data;
  logic [ND-1:0]   frame_blank;
  logic            frame_err;
  logic            frame_valid;
  logic            overrun;

  seg7_scan_decoder #(.NUM_DIG(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_data  (frame_data),
    .frame_blank (frame_blank),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Segment pattern for each hex value, index = nibble
  logic [6:0] pat_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference state
  logic [6:0]      p_seg;
  logic [ND-1:0]   p_an;
  int              run;
  bit              hit_prev;
  logic [6:0]      hit_seg;
  logic [ND-1:0]   hit_an;
  logic [3:0]      w_nib [ND];
  logic [ND-1:0]   w_blank, w_mask;
  bit              w_err, w_compl;
  logic [4*ND-1:0] m_data;
  logic [ND-1:0]   m_blank;
  bit              m_err, m_valid, m_ovr;

  // Observation counters
  int              valid_rises, valid_cnt, ovr_count;
  bit              prev_valid;
  logic [4*ND-1:0] last_data;
  logic [ND-1:0]   last_blank;
  bit              last_err;

  function automatic void decode(input logic [6:0] p, output logic [3:0] nib,
                                 output bit blk, output bit er);
    nib = 4'h0;
    blk = (p == BLANK);
    er  = !blk;
    for (int k = 0; k < 16; k++)
      if (pat_tab[k] == p) begin
        nib = 4'(k);
        er  = 1'b0;
      end
  endfunction

  task automatic model_clear();
    p_seg = '0; p_an = '0; run = 0;
    hit_prev = 1'b0; hit_seg = '0; hit_an = '1;
    for (int i = 0; i < ND; i++) w_nib[i] = 4'h0;
    w_blank = '0; w_mask = '0; w_err = 1'b0; w_compl = 1'b0;
    m_data = '0; m_blank = '0; m_err = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    prev_valid = 1'b0;
  endtask

  task automatic clear_counts();
    valid_rises = 0; valid_cnt = 0; ovr_count = 0;
    last_data = '0; last_blank = '0; last_err = 1'b0;
  endtask

  // Drive one cycle of bus input, advance the reference, compare outputs.
  // A capture happens one edge after the input run of identical qualified
  // values first reaches SC (the input passes through the sample register).
  task automatic cycle(input logic [6:0] s, input logic [ND-1:0] a, input bit rdy);
    bit qual, hit_now, blk, er;
    logic [3:0] nib;
    int d;
    seg_n = s; an_n = a; frame_ready = rdy;
    qual    = ($countones(~a) == 1);
    hit_now = 1'b0;
    if (qual && s == p_seg && a == p_an) begin
      if (run < SC) begin
        run++;
        hit_now = (run == SC);
      end
    end else begin
      run = qual ? 1 : 0;
    end
    p_seg = s; p_an = a;

    @(posedge clk); #1;

    m_ovr = 1'b0;
    if (w_compl) begin
      if (!m_valid || rdy) begin
        for (int i = 0; i < ND; i++) m_data[4*i +: 4] = w_nib[i];
        m_blank = w_blank; m_err = w_err; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      w_mask = '0; w_err = 1'b0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (hit_prev) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (!hit_an[i]) d = i;
      decode(hit_seg, nib, blk, er);
      w_nib[d] = nib; w_blank[d] = blk; w_mask[d] = 1'b1;
      w_err = w_err | er;
    end
    w_compl  = &w_mask;
    hit_prev = hit_now; hit_seg = s; hit_an = a;

    chk("valid",   32'(frame_valid), 32'(m_valid));
    chk("data",    32'(frame_data),  32'(m_data));
    chk("blank",   32'(frame_blank), 32'(m_blank));
    chk("err",     32'(frame_err),   32'(m_err));
    chk("overrun", 32'(overrun),     32'(m_ovr));

    if (frame_valid && !prev_valid) valid_rises++;
    prev_valid = frame_valid;
    if (frame_valid) begin
      valid_cnt++;
      last_data = frame_data; last_blank = frame_blank; last_err = frame_err;
    end
    if (overrun) ovr_count++;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(BLANK, '1, rdy);
  endtask

  function automatic logic [7*ND-1:0] pk(input logic [6:0] d0, input logic [6:0] d1,
                                         input logic [6:0] d2, input logic [6:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic scan(input logic [7*ND-1:0] pats, input int hold, input bit rdy,
                      input int first, input int last);
    logic [ND-1:0] a;
    for (int d = first; d <= last; d++) begin
      a = '1; a[d] = 1'b0;
      repeat (hold) cycle(pats[7*d +: 7], a, rdy);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_valid",   32'(frame_valid), 32'd0);
    chk("rst_data",    32'(frame_data),  32'd0);
    chk("rst_blank",   32'(frame_blank), 32'd0);
    chk("rst_err",     32'(frame_err),   32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int d, hold, r;
    logic [6:0] pat;
    logic [ND-1:0] a;

    rst_n = 1'b1; seg_n = BLANK; an_n = '1; frame_ready = 1'b1;
    model_clear();
    clear_counts();
    #3;
    reset_pulse();

    // Scan "1234"
    clear_counts();
    scan(pk(pat_tab[4], pat_tab[3], pat_tab[2], pat_tab[1]), 8, 1'b1, 0, 3);
    idle(3, 1'b1);
    chk("f1234_data",  32'(last_data),  32'h1234);
    chk("f1234_blank", 32'(last_blank), 32'h0);
    chk("f1234_err",   32'(last_err),   32'h0);
    chk("f1234_vcyc",  32'(valid_cnt),  32'd1);

    // Last digit held too briefly to capture
    clear_counts();
    scan(pk(pat_tab[5], pat_tab[6], pat_tab[7], pat_tab[8]), 8, 1'b1, 0, 2);
    scan(pk(pat_tab[5], pat_tab[6], pat_tab[7], pat_tab[8]), SC - 1, 1'b1, 3, 3);
    idle(6, 1'b1);
    chk("short_rises", 32'(valid_rises), 32'd0);

    // Blank and unrecognised digits
    clear_counts();
    scan(pk(pat_tab[5], 7'b1111110, BLANK, pat_tab[7]), 8, 1'b1, 0, 3);
    idle(3, 1'b1);
    chk("blkerr_data",  32'(last_data),   32'h7005);
    chk("blkerr_blank", 32'(last_blank),  32'h4);
    chk("blkerr_err",   32'(last_err),    32'h1);
    chk("blkerr_rises", 32'(valid_rises), 32'd1);

    // Stalled consumer across two frames
    clear_counts();
    scan(pk(pat_tab[9], pat_tab[8], pat_tab[10], pat_tab[11]), 8, 1'b0, 0, 3);
    scan(pk(pat_tab[1], pat_tab[2], pat_tab[3], pat_tab[4]), 8, 1'b0, 0, 3);
    idle(3, 1'b0);
    chk("stall_data",  32'(frame_data),  32'hBA89);
    chk("stall_valid", 32'(frame_valid), 32'd1);
    chk("stall_ovr",   32'(ovr_count),   32'd1);
    idle(6, 1'b1);
    chk("stall_after_valid", 32'(frame_valid), 32'd0);
    chk("stall_rises",       32'(valid_rises), 32'd1);

    // Two anodes low, then a clean scan
    clear_counts();
    repeat (10) cycle(pat_tab[8], 4'b0011, 1'b1);
    chk("multi_rises", 32'(valid_rises), 32'd0);
    scan(pk(pat_tab[12], pat_tab[13], pat_tab[14], pat_tab[15]), 8, 1'b1, 0, 3);
    idle(3, 1'b1);
    chk("multi_data",  32'(last_data),   32'hFEDC);
    chk("multi_rises2", 32'(valid_rises), 32'd1);

    // Reset after a held frame and two captured digits
    clear_counts();
    scan(pk(pat_tab[1], pat_tab[2], pat_tab[3], pat_tab[4]), 8, 1'b0, 0, 3);
    scan(pk(pat_tab[6], pat_tab[7], pat_tab[0], pat_tab[5]), 8, 1'b0, 0, 1);
    chk("prerst_valid", 32'(frame_valid), 32'd1);
    chk("prerst_data",  32'(frame_data),  32'h4321);
    reset_pulse();
    clear_counts();
    scan(pk(pat_tab[6], pat_tab[7], pat_tab[0], pat_tab[5]), 8, 1'b1, 2, 3);
    idle(4, 1'b1);
    chk("postrst_partial", 32'(valid_rises), 32'd0);
    scan(pk(pat_tab[6], pat_tab[7], pat_tab[0], pat_tab[5]), 8, 1'b1, 0, 3);
    idle(3, 1'b1);
    chk("postrst_data",  32'(last_data),   32'h5076);
    chk("postrst_rises", 32'(valid_rises), 32'd1);

    // Randomized scanning with random consumer back-pressure
    d = 0;
    for (int w = 0; w < 300; w++) begin
      if ($urandom_range(0, 99) < 15) d = $urandom_range(0, ND - 1);
      else d = (d + 1) % ND;
      r = $urandom_range(0, 99);
      if (r < 80)      pat = pat_tab[$urandom_range(0, 15)];
      else if (r < 90) pat = BLANK;
      else             pat = 7'($urandom);
      a = '1; a[d] = 1'b0;
      if ($urandom_range(0, 9) == 0) a = ND'($urandom);
      hold = $urandom_range(1, 10);
      repeat (hold) cycle(pat, a, ($urandom_range(0, 9) < 7));
      if (w == 150) reset_pulse();
    end
    idle(5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
